// File: rtl/cphy_esc_pkg.sv
// Shared constants, state type and line helpers for the C-PHY escape-mode RX path.
package cphy_esc_pkg;

    // Escape entry commands, transmitted MSB first
    localparam logic [7:0] ESC_CMD_LPDT = 8'b1110_0001;
    localparam logic [7:0] ESC_CMD_ULPS = 8'b0001_1110;

    // Trigger entries: index 0 = Reset-Trigger, 1..3 = Unknown-3/4/5
    localparam logic [7:0] ESC_CMD_TRIG [0:3] = '{
        8'b0110_0010,
        8'b0101_1101,
        8'b0010_0001,
        8'b1010_0000
    };

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        LPDT = 3'd2,
        ULPS = 3'd3,
        WAIT = 3'd4
    } esc_state_t;

    // All three wires high marks the LP stop state
    function automatic logic esc_is_stop(input logic a, input logic b, input logic c);
        return a & b & c;
    endfunction

endpackage

// File: rtl/esc_bit_deser.sv
// Serial-to-parallel shifter shared by the command and LPDT phases.
// i_len selects the word length; i_data_mode applies LSB_FIRST ordering,
// otherwise bits are packed MSB first into the low i_len bits.
module esc_bit_deser #(
    parameter int unsigned W         = 8,
    parameter bit          LSB_FIRST = 1'b1,
    localparam int unsigned CW       = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          i_clr,
    input  logic          i_shift,
    input  logic          i_bit,
    input  logic          i_data_mode,
    input  logic [CW-1:0] i_len,
    output logic [W-1:0]  o_next,
    output logic [CW-1:0] o_cnt,
    output logic          o_full
);

    logic [W-1:0]  r_sr;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  w_next;
    logic          w_full;

    // Value the register takes if the current bit is shifted in
    always_comb begin
        w_next = '0;
        if (i_data_mode && LSB_FIRST) begin
            for (int unsigned k = 0; k < W; k++) begin
                if (k + 1 < 32'(i_len))
                    w_next[k] = r_sr[k + 1];
                else if (k + 1 == 32'(i_len))
                    w_next[k] = i_bit;
            end
        end else begin
            w_next = {r_sr[W-2:0], i_bit};
        end
    end

    assign w_full = i_shift && (r_cnt == i_len - 1'b1);

    // Shift register and bit counter; counter wraps to zero on a full word
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sr  <= w_next;
            r_cnt <= w_full ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_next = w_next;
    assign o_cnt  = r_cnt;
    assign o_full = w_full;

endmodule

// File: rtl/esc_mode_rx_decoder.sv
// Escape-mode receive decoder: command entry decode, LPDT deserialisation,
// ULPS / trigger reporting and stop/sync/control error strobes.
module esc_mode_rx_decoder
    import cphy_esc_pkg::*;
#(
    parameter int unsigned CMD_W     = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_TRIG  = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                EscDecoderEn,
    input  logic                A,
    input  logic                B,
    input  logic                C,
    input  logic                RequestDetection,
    output logic                RxLpdtEsc,
    output logic                RxUlpsEsc,
    output logic [NUM_TRIG-1:0] RxTriggerEsc,
    output logic [DATA_W-1:0]   RxDataEsc,
    output logic                RxValidEsc,
    output logic                ErrEsc,
    output logic                ErrSyncEsc,
    output logic                ErrControl,
    output logic                LpFsmStop
);

    localparam int unsigned DESER_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int unsigned LEN_W   = $clog2(DESER_W + 1);

    esc_state_t            r_state;
    logic                  r_lpdt;
    logic                  r_ulps;
    logic [NUM_TRIG-1:0]   r_trig;
    logic [DATA_W-1:0]     r_data;
    logic                  r_valid;
    logic                  r_err;
    logic                  r_err_sync;
    logic                  r_err_ctrl;
    logic                  r_stop;

    logic                  w_stop;
    logic                  w_shift;
    logic                  w_clr;
    logic                  w_data_mode;
    logic [LEN_W-1:0]      w_len;
    logic [DESER_W-1:0]    w_next;
    logic [LEN_W-1:0]      w_cnt;
    logic                  w_full;
    logic [CMD_W-1:0]      w_cmd;
    logic [3:0]            w_trig_hit;

    assign w_stop      = esc_is_stop(A, B, C);
    assign w_data_mode = (r_state == LPDT);
    assign w_len       = w_data_mode ? LEN_W'(DATA_W) : LEN_W'(CMD_W);
    assign w_shift     = EscDecoderEn && !w_stop &&
                         (r_state == IDLE || r_state == CMD || r_state == LPDT);
    assign w_clr       = !EscDecoderEn || w_stop || r_state == ULPS || r_state == WAIT;
    assign w_cmd       = w_next[CMD_W-1:0];

    esc_bit_deser #(
        .W         (DESER_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_deser (
        .clk         (clk),
        .RST         (RST),
        .i_clr       (w_clr),
        .i_shift     (w_shift),
        .i_bit       (A),
        .i_data_mode (w_data_mode),
        .i_len       (w_len),
        .o_next      (w_next),
        .o_cnt       (w_cnt),
        .o_full      (w_full)
    );

    // Match the completing command against the trigger table
    always_comb begin
        w_trig_hit = '0;
        for (int unsigned t = 0; t < 4; t++) begin
            if (w_cmd == CMD_W'(ESC_CMD_TRIG[t]))
                w_trig_hit[t] = 1'b1;
        end
    end

    // Main FSM with registered levels, strobes and error pulses
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_lpdt     <= 1'b0;
            r_ulps     <= 1'b0;
            r_trig     <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_err_sync <= 1'b0;
            r_err_ctrl <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_err_ctrl <= w_stop & RequestDetection;
            r_trig     <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_err_sync <= 1'b0;
            r_stop     <= 1'b0;
            if (!EscDecoderEn) begin
                r_state <= IDLE;
                r_lpdt  <= 1'b0;
                r_ulps  <= 1'b0;
            end else if (w_stop) begin
                if (r_state != IDLE) begin
                    r_stop     <= 1'b1;
                    r_err_sync <= (r_state == CMD) || (r_state == LPDT && w_cnt != '0);
                end
                r_state <= IDLE;
                r_lpdt  <= 1'b0;
                r_ulps  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: r_state <= CMD;
                    CMD: begin
                        if (w_full) begin
                            if (w_cmd == CMD_W'(ESC_CMD_LPDT)) begin
                                r_state <= LPDT;
                                r_lpdt  <= 1'b1;
                            end else if (w_cmd == CMD_W'(ESC_CMD_ULPS)) begin
                                r_state <= ULPS;
                                r_ulps  <= 1'b1;
                            end else if (|w_trig_hit[NUM_TRIG-1:0]) begin
                                r_state <= WAIT;
                                r_trig  <= w_trig_hit[NUM_TRIG-1:0];
                            end else begin
                                r_state <= WAIT;
                                r_err   <= 1'b1;
                            end
                        end
                    end
                    LPDT: begin
                        if (w_full) begin
                            r_data  <= w_next[DATA_W-1:0];
                            r_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign RxLpdtEsc    = r_lpdt;
    assign RxUlpsEsc    = r_ulps;
    assign RxTriggerEsc = r_trig;
    assign RxDataEsc    = r_data;
    assign RxValidEsc   = r_valid;
    assign ErrEsc       = r_err;
    assign ErrSyncEsc   = r_err_sync;
    assign ErrControl   = r_err_ctrl;
    assign LpFsmStop    = r_stop;

endmodule

// File: tb/tb_esc_mode_rx_decoder.sv
// Directed bench for esc_mode_rx_decoder: LPDT, sync error, triggers
// (NUM_TRIG=4 and NUM_TRIG=1), bad command, ULPS, reset abort, ErrControl.
module tb_esc_mode_rx_decoder;

    logic       clk = 1'b0;
    logic       RST = 1'b0;
    logic       EscDecoderEn = 1'b0;
    logic       A = 1'b0;
    logic       B = 1'b0;
    logic       C = 1'b0;
    logic       RequestDetection = 1'b0;

    logic       lpdt, ulps, valid, err, esync, ectrl, lstop;
    logic [3:0] trig;
    logic [7:0] data;

    logic       lpdt1, ulps1, valid1, err1, esync1, ectrl1, lstop1;
    logic [0:0] trig1;
    logic [7:0] data1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    esc_mode_rx_decoder #(.CMD_W(8), .DATA_W(8), .NUM_TRIG(4), .LSB_FIRST(1'b1)) u_dut (
        .clk(clk), .RST(RST), .EscDecoderEn(EscDecoderEn), .A(A), .B(B), .C(C),
        .RequestDetection(RequestDetection), .RxLpdtEsc(lpdt), .RxUlpsEsc(ulps),
        .RxTriggerEsc(trig), .RxDataEsc(data), .RxValidEsc(valid), .ErrEsc(err),
        .ErrSyncEsc(esync), .ErrControl(ectrl), .LpFsmStop(lstop)
    );

    esc_mode_rx_decoder #(.CMD_W(8), .DATA_W(8), .NUM_TRIG(1), .LSB_FIRST(1'b1)) u_dut1 (
        .clk(clk), .RST(RST), .EscDecoderEn(EscDecoderEn), .A(A), .B(B), .C(C),
        .RequestDetection(RequestDetection), .RxLpdtEsc(lpdt1), .RxUlpsEsc(ulps1),
        .RxTriggerEsc(trig1), .RxDataEsc(data1), .RxValidEsc(valid1), .ErrEsc(err1),
        .ErrSyncEsc(esync1), .ErrControl(ectrl1), .LpFsmStop(lstop1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Apply one line state at the falling edge, then settle past the rising edge
    task automatic drive(input logic en, input logic a, input logic b, input logic c);
        @(negedge clk);
        EscDecoderEn = en;
        A = a;
        B = b;
        C = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n, input bit lsb);
        logic [15:0] tmp;
        tmp = v;
        for (int i = 0; i < n; i++)
            drive(1'b1, lsb ? tmp[i] : tmp[n-1-i], 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] all_outs();
        return {13'd0, lpdt, ulps, trig, valid, err, esync, ectrl, lstop, data};
    endfunction

    logic [7:0] codes [0:3] = '{8'b0110_0010, 8'b0101_1101, 8'b0010_0001, 8'b1010_0000};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_all", all_outs(), 32'd0);
        @(negedge clk);
        RST = 1'b1;

        // T1: LPDT with two words then clean stop
        send_bits(16'h0070, 7, 1'b0);
        check("t1_lpdt_before", {31'd0, lpdt}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("t1_lpdt_rise", {31'd0, lpdt}, 32'd1);
        send_bits(16'h00A5, 7, 1'b1);
        check("t1_valid_early", {31'd0, valid}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("t1_valid0", {31'd0, valid}, 32'd1);
        check("t1_data0", {24'd0, data}, 32'hA5);
        send_bits(16'h003C, 8, 1'b1);
        check("t1_valid1", {31'd0, valid}, 32'd1);
        check("t1_data1", {24'd0, data}, 32'h3C);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("t1_stop", {29'd0, lstop, esync, valid}, 32'b100);
        check("t1_lpdt_clr", {30'd0, lpdt, ectrl}, 32'd0);
        check("t1_data_hold", {24'd0, data}, 32'h3C);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_stop_pulse", {31'd0, lstop}, 32'd0);

        // T2: stop after a partial word
        send_bits(16'h00E1, 8, 1'b0);
        send_bits(16'h00A5, 8, 1'b1);
        check("t2_data0", {23'd0, valid, data}, 32'h1A5);
        send_bits(16'h0005, 3, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("t2_sync", {29'd0, lstop, esync, valid}, 32'b110);
        check("t2_data_hold", {24'd0, data}, 32'hA5);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_sync_pulse", {31'd0, esync}, 32'd0);

        // T3: triggers on both parameterisations
        for (int i = 0; i < 4; i++) begin
            send_bits({8'd0, codes[i]}, 8, 1'b0);
            check($sformatf("t3_trig%0d", i), {28'd0, trig}, 32'd1 << i);
            check($sformatf("t3_err%0d", i), {31'd0, err}, 32'd0);
            check($sformatf("t3_n1_trig%0d", i), {31'd0, trig1}, (i == 0) ? 32'd1 : 32'd0);
            check($sformatf("t3_n1_err%0d", i), {31'd0, err1}, (i == 0) ? 32'd0 : 32'd1);
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("t3_trig_pulse%0d", i), {28'd0, trig}, 32'd0);
            drive(1'b1, 1'b1, 1'b1, 1'b1);
            check($sformatf("t3_stop%0d", i), {30'd0, lstop, esync}, 32'b10);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
        end

        // T4a: unknown command, then line ignored until stop
        send_bits(16'h00FF, 8, 1'b0);
        check("t4_err", {31'd0, err}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i[0], 1'b0, 1'b0);
            check($sformatf("t4_wait%0d", i), {25'd0, lpdt, ulps, trig, err}, 32'd0);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("t4_stop", {30'd0, lstop, esync}, 32'b10);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // T4b: ULPS held through line activity, cleared by disable
        send_bits(16'h001E, 8, 1'b0);
        check("t4_ulps", {31'd0, ulps}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, i[0], 1'b0, 1'b0);
            check($sformatf("t4_ulps_hold%0d", i), {29'd0, ulps, valid, err}, 32'b100);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_ulps_off", {27'd0, ulps, err, esync, ectrl, lstop}, 32'd0);

        // T5: async reset mid-LPDT, then ErrControl
        send_bits(16'h00E1, 8, 1'b0);
        send_bits(16'h0005, 4, 1'b1);
        check("t5_lpdt_pre", {31'd0, lpdt}, 32'd1);
        @(negedge clk);
        RST = 1'b0;
        #1;
        check("t5_reset_all", all_outs(), 32'd0);
        EscDecoderEn = 1'b0;
        @(negedge clk);
        RST = 1'b1;
        RequestDetection = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check("t5_errctrl", {30'd0, ectrl, lstop}, 32'b10);
        RequestDetection = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_errctrl_pulse", {31'd0, ectrl}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
